// File: rtl/arbiter_wrr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_wrr_pkg
// Description : Shared state encodings and constant helpers for arbiter_wrr.
// Revision    : 1.0 - initial release
// ============================================================================
package arbiter_wrr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Elaboration-time ceil(log2(v)); callers clamp the result to at least 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_pick
// Description : Finds the first requesting port strictly after a base index,
//               wrapping around; the base port itself is examined last.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr_pick #(
    parameter int NUM_PORTS = 6,
    parameter int ID_W      = 3
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [ID_W-1:0]      base,
    output logic [NUM_PORTS-1:0] pick,
    output logic [ID_W-1:0]      pick_id,
    output logic                 found
);

    int w_idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = (int'(base) + k) % NUM_PORTS;
            if (!found && request[w_idx]) begin
                found        = 1'b1;
                pick[w_idx]  = 1'b1;
                pick_id      = ID_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_wrr
// Description : Weighted round-robin arbiter with per-port burst credit,
//               back-to-back hand-over and encoded grant index.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_wrr
    import arbiter_wrr_pkg::*;
#(
    parameter  int NUM_PORTS = 6,
    parameter  int WEIGHT_W  = 4,
    localparam int ID_W      = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          request,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [ID_W-1:0]               grant_id,
    output logic                          active
);

    localparam logic [ID_W-1:0]     c_last_rst = ID_W'(NUM_PORTS - 1);
    localparam logic [WEIGHT_W-1:0] c_one      = WEIGHT_W'(1);

    state_t                r_state;
    logic [ID_W-1:0]       r_owner;
    logic [ID_W-1:0]       r_last;
    logic [WEIGHT_W-1:0]   r_credit;
    logic [NUM_PORTS-1:0]  r_grant;
    logic [ID_W-1:0]       r_grant_id;

    logic [ID_W-1:0]       w_base;
    logic [NUM_PORTS-1:0]  w_pick;
    logic [ID_W-1:0]       w_pick_id;
    logic                  w_found;
    logic                  w_other;
    logic                  w_owner_req;
    logic [WEIGHT_W-1:0]   w_owner_wt;
    logic [WEIGHT_W-1:0]   w_pick_wt;
    logic [WEIGHT_W-1:0]   w_owner_load;
    logic [WEIGHT_W-1:0]   w_pick_load;

    assign w_base = (r_state == ST_OWN) ? r_owner : r_last;

    arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_pick (
        .request (request),
        .base    (w_base),
        .pick    (w_pick),
        .pick_id (w_pick_id),
        .found   (w_found)
    );

    always_comb begin
        w_owner_req = 1'b0;
        w_owner_wt  = '0;
        w_pick_wt   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_owner == ID_W'(i)) begin
                w_owner_req = request[i];
                w_owner_wt  = weight[i*WEIGHT_W +: WEIGHT_W];
            end
            if (w_pick_id == ID_W'(i)) begin
                w_pick_wt = weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    // A zero weight behaves as one, so the loaded credit saturates at zero.
    assign w_owner_load = (w_owner_wt == '0) ? '0 : w_owner_wt - c_one;
    assign w_pick_load  = (w_pick_wt  == '0) ? '0 : w_pick_wt  - c_one;
    assign w_other      = w_found && (w_pick_id != r_owner);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_last     <= c_last_rst;
            r_credit   <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_OWN;
                        r_owner    <= w_pick_id;
                        r_credit   <= w_pick_load;
                        r_grant    <= w_pick;
                        r_grant_id <= w_pick_id;
                    end
                end
                ST_OWN: begin
                    if (!w_owner_req) begin
                        r_last <= r_owner;
                        if (w_found) begin
                            r_owner    <= w_pick_id;
                            r_credit   <= w_pick_load;
                            r_grant    <= w_pick;
                            r_grant_id <= w_pick_id;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                    end else if (r_credit == '0) begin
                        if (w_other) begin
                            r_owner    <= w_pick_id;
                            r_credit   <= w_pick_load;
                            r_grant    <= w_pick;
                            r_grant_id <= w_pick_id;
                        end else begin
                            r_credit <= w_owner_load;
                        end
                    end else begin
                        r_credit <= r_credit - c_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign active   = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_wrr
// Description : Directed scoreboard bench for arbiter_wrr (6 ports, 4-bit weights).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_wrr;

    logic        clk;
    logic        rst;
    logic [5:0]  request;
    logic [23:0] weight;
    logic [5:0]  grant;
    logic [2:0]  grant_id;
    logic        active;

    typedef struct {
        int         cyc;
        int         tag;
        logic [5:0] g;
        logic [2:0] id;
        logic       act;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   cyc     = 0;
    int   tag     = 0;
    int   n_check = 0;
    int   n_pass  = 0;

    arbiter_wrr #(
        .NUM_PORTS (6),
        .WEIGHT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .request  (request),
        .weight   (weight),
        .grant    (grant),
        .grant_id (grant_id),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            n_check = n_check + 1;
            if (m_e.cyc == cyc && grant === m_e.g && grant_id === m_e.id && active === m_e.act) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL step%0d: got grant=%b id=%0d active=%b, expected grant=%b id=%0d active=%b",
                         m_e.tag, grant, grant_id, active, m_e.g, m_e.id, m_e.act);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [5:0] req, input logic [23:0] wt,
                        input logic [5:0] g, input logic [2:0] id);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        request = req;
        weight  = wt;
        e.cyc   = cyc + 1;
        e.tag   = tag;
        e.g     = g;
        e.id    = id;
        e.act   = |g;
        exp_q.push_back(e);
        tag = tag + 1;
    endtask

    function automatic logic [5:0] oh(input int p);
        logic [5:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    localparam logic [23:0] W_ALL1 = {6{4'h1}};
    localparam logic [23:0] W_ALL2 = {6{4'h2}};
    localparam logic [23:0] W_ALL4 = {6{4'h4}};
    localparam logic [23:0] W_ALL0 = {6{4'h0}};
    localparam logic [23:0] W_P1_3 = {4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'h1};
    localparam logic [23:0] W_P3_4 = {4'h1, 4'h1, 4'h4, 4'h1, 4'h1, 4'h1};

    initial begin
        int seq2[13];
        int seq3[8];
        seq2 = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};
        seq3 = '{0, 1, 1, 1, 0, 1, 1, 1};
        rst     = 1'b1;
        request = '0;
        weight  = W_ALL1;
        repeat (2) @(posedge clk);

        // Reset state, then single request on port 2
        step(1'b1, 6'b000000, W_ALL1, 6'b000000, 3'd0);
        step(1'b0, 6'b000000, W_ALL1, 6'b000000, 3'd0);
        step(1'b0, 6'b000100, W_ALL1, 6'b000100, 3'd2);
        step(1'b0, 6'b000000, W_ALL1, 6'b000000, 3'd2);

        // Equal weights of 2, all ports requesting
        step(1'b1, 6'b000000, W_ALL2, 6'b000000, 3'd0);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 6'b111111, W_ALL2, oh(seq2[i]), 3'(seq2[i]));
        end
        step(1'b0, 6'b000000, W_ALL2, 6'b000000, 3'd0);

        // Port 1 weight 3 against port 0 weight 1
        step(1'b1, 6'b000000, W_P1_3, 6'b000000, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 6'b000011, W_P1_3, oh(seq3[i]), 3'(seq3[i]));
        end
        step(1'b0, 6'b000000, W_P1_3, 6'b000000, 3'd1);

        // Early release by port 3 hands over to port 5 without a bubble
        step(1'b1, 6'b000000, W_P3_4, 6'b000000, 3'd0);
        step(1'b0, 6'b001000, W_P3_4, 6'b001000, 3'd3);
        step(1'b0, 6'b001000, W_P3_4, 6'b001000, 3'd3);
        step(1'b0, 6'b100000, W_P3_4, 6'b100000, 3'd5);
        step(1'b0, 6'b000000, W_P3_4, 6'b000000, 3'd5);

        // Sole requester keeps the grant; zero weights give 1-cycle bursts
        step(1'b1, 6'b000000, W_ALL1, 6'b000000, 3'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 6'b010000, W_ALL1, 6'b010000, 3'd4);
        end
        step(1'b0, 6'b000000, W_ALL0, 6'b000000, 3'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'b000011, W_ALL0, oh(i % 2), 3'(i % 2));
        end
        step(1'b0, 6'b000000, W_ALL0, 6'b000000, 3'd1);

        // Reset mid-grant clears priority of the previous owner
        step(1'b1, 6'b000000, W_ALL4, 6'b000000, 3'd0);
        step(1'b0, 6'b000100, W_ALL4, 6'b000100, 3'd2);
        step(1'b0, 6'b000101, W_ALL4, 6'b000100, 3'd2);
        step(1'b1, 6'b000101, W_ALL4, 6'b000000, 3'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'b000101, W_ALL4, 6'b000001, 3'd0);
        end
        step(1'b0, 6'b000101, W_ALL4, 6'b000100, 3'd2);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_check = n_check + 1;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
